// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   fwd_sel_t  : ALU operand source select (regfile, X/M, M/W)
//   md_state_t : multiply/divide sequencer states
//   md_status_t: sequencer status bundle handed up to hazard_ctrl
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_XM = 2'b01;
  localparam fwd_sel_t FWD_MW = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  typedef struct packed {
    logic busy;
    logic done;
  } md_status_t;

endpackage

// File: rtl/md_seq.sv
// Multiply/divide latency sequencer.
//   clock, aclr : clock, async active-low reset
//   start       : D/X holds a multdiv op (ignored unless IDLE or DONE)
//   flush       : taken control transfer; aborts a running op, blocks a start
//   st          : {busy, done}; done is a one-cycle pulse MD_LAT cycles after start
module md_seq
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 8
) (
  input  logic       clock,
  input  logic       aclr,
  input  logic       start,
  input  logic       flush,
  output md_status_t st
);

  // Loading MD_LAT-2 gives MD_LAT-1 BUSY cycles followed by the DONE cycle.
  localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 2);

  md_state_t  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st.busy   = 1'b0;
    st.done   = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (start && !flush) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        st.busy = 1'b1;
        if (flush) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 8'd0) begin
          state_nxt = MD_DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      MD_DONE: begin
        st.done = 1'b1;
        if (start && !flush) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = MD_IDLE;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use
// interlock, multdiv stall sequencing, and a saturating stall counter.
//   fd_*/dx_*/xm_*/mw_* : register fields of the pipeline latches
//   dx_md_start         : D/X holds a multiply/divide op
//   flush               : taken branch/jump resolved this cycle
//   fwd_a, fwd_b        : ALU operand selects (FWD_RF / FWD_XM / FWD_MW)
//   stall_fd, stall_dx  : hold PC+F/D, hold D/X
//   bubble_dx           : load NOP into D/X next edge
//   md_busy, md_done    : multdiv running / completion pulse
//   stall_cnt           : saturating count of stall_fd cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW     = 5,
  parameter int MD_LAT = 8,
  parameter int SCW    = 16
) (
  input  logic           clock,
  input  logic           aclr,
  input  logic [RW-1:0]  fd_rs1,
  input  logic [RW-1:0]  fd_rs2,
  input  logic [RW-1:0]  dx_rs1,
  input  logic [RW-1:0]  dx_rs2,
  input  logic [RW-1:0]  dx_rd,
  input  logic           dx_regwr,
  input  logic           dx_load,
  input  logic [RW-1:0]  xm_rd,
  input  logic           xm_regwr,
  input  logic [RW-1:0]  mw_rd,
  input  logic           mw_regwr,
  input  logic           dx_md_start,
  input  logic           flush,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           stall_fd,
  output logic           stall_dx,
  output logic           bubble_dx,
  output logic           md_busy,
  output logic           md_done,
  output logic [SCW-1:0] stall_cnt
);

  md_status_t md_st;
  logic       load_use;

  md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clock (clock),
    .aclr  (aclr),
    .start (dx_md_start),
    .flush (flush),
    .st    (md_st)
  );

  assign md_busy = md_st.busy;
  assign md_done = md_st.done;

  // r0 is hardwired zero, so a write to it is never a real producer.
  function automatic fwd_sel_t pick(input logic [RW-1:0] rs);
    if (xm_regwr && xm_rd != '0 && xm_rd == rs)      return FWD_XM;
    else if (mw_regwr && mw_rd != '0 && mw_rd == rs) return FWD_MW;
    else                                             return FWD_RF;
  endfunction

  assign load_use = dx_load && dx_regwr && (dx_rd != '0) &&
                    ((dx_rd == fd_rs1) || (dx_rd == fd_rs2));

  always_comb begin
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    if (aclr) begin
      fwd_a = pick(dx_rs1);
      fwd_b = pick(dx_rs2);
      if (flush) begin
        bubble_dx = 1'b1;
      end else if (md_st.busy) begin
        // D/X is frozen on the multdiv op, so no bubble even on load-use.
        stall_fd = 1'b1;
        stall_dx = 1'b1;
      end else if (load_use) begin
        stall_fd  = 1'b1;
        bubble_dx = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr)
      stall_cnt <= '0;
    else if (stall_fd && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clock, aclr;
  logic [4:0] fd_rs1, fd_rs2, dx_rs1, dx_rs2, dx_rd, xm_rd, mw_rd;
  logic       dx_regwr, dx_load, xm_regwr, mw_regwr, dx_md_start, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_fd, stall_dx, bubble_dx, md_busy, md_done;
  logic [3:0] stall_cnt;

  hazard_ctrl #(.RW(5), .MD_LAT(8), .SCW(4)) dut (
    .clock(clock), .aclr(aclr),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .dx_rs1(dx_rs1), .dx_rs2(dx_rs2),
    .dx_rd(dx_rd), .dx_regwr(dx_regwr), .dx_load(dx_load),
    .xm_rd(xm_rd), .xm_regwr(xm_regwr), .mw_rd(mw_rd), .mw_regwr(mw_regwr),
    .dx_md_start(dx_md_start), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    fd_rs1 = '0; fd_rs2 = '0; dx_rs1 = '0; dx_rs2 = '0; dx_rd = '0;
    xm_rd = '0; mw_rd = '0; dx_regwr = 0; dx_load = 0; xm_regwr = 0;
    mw_regwr = 0; dx_md_start = 0; flush = 0;
  endtask

  task automatic set_lu();
    dx_load = 1; dx_regwr = 1; dx_rd = 5'd3; fd_rs2 = 5'd3;
  endtask

  task automatic chk_stall(input string nm, input logic sf, input logic sd, input logic bb);
    chk({nm, ".stall_fd"}, 32'(stall_fd), 32'(sf));
    chk({nm, ".stall_dx"}, 32'(stall_dx), 32'(sd));
    chk({nm, ".bubble_dx"}, 32'(bubble_dx), 32'(bb));
  endtask

  typedef struct {
    logic [4:0] fd1, fd2, rs1, rs2, rd;
    logic       regwr, load;
    logic [4:0] xrd;
    logic       xwr;
    logic [4:0] mrd;
    logic       mwr, fl;
    logic [1:0] efa, efb;
    logic       esf, esd, ebb;
  } vec_t;

  function automatic vec_t mk(int fd1, int fd2, int rs1, int rs2, int rd, int regwr, int load,
                              int xrd, int xwr, int mrd, int mwr, int fl,
                              int efa, int efb, int esf, int esd, int ebb);
    vec_t v;
    v.fd1 = 5'(fd1); v.fd2 = 5'(fd2); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.regwr = 1'(regwr); v.load = 1'(load); v.xrd = 5'(xrd); v.xwr = 1'(xwr);
    v.mrd = 5'(mrd); v.mwr = 1'(mwr); v.fl = 1'(fl);
    v.efa = 2'(efa); v.efb = 2'(efb); v.esf = 1'(esf); v.esd = 1'(esd); v.ebb = 1'(ebb);
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    //            fd1 fd2 rs1 rs2 rd wr ld xrd xw mrd mw fl  fa fb sf sd bb
    vecs[0]  = mk(0,  0,  5,  6,  0, 0, 0, 5,  1, 5,  1, 0,  1, 0, 0, 0, 0);
    vecs[1]  = mk(0,  0,  5,  6,  0, 0, 0, 5,  0, 5,  1, 0,  2, 0, 0, 0, 0);
    vecs[2]  = mk(0,  0,  0,  0,  0, 0, 0, 0,  1, 0,  1, 0,  0, 0, 0, 0, 0);
    vecs[3]  = mk(0,  0,  1,  7,  0, 0, 0, 7,  0, 7,  1, 0,  0, 2, 0, 0, 0);
    vecs[4]  = mk(0,  0,  9,  9,  0, 0, 0, 9,  1, 9,  1, 0,  1, 1, 0, 0, 0);
    vecs[5]  = mk(0,  3,  0,  0,  3, 1, 1, 0,  0, 0,  0, 0,  0, 0, 1, 0, 1);
    vecs[6]  = mk(4,  0,  0,  0,  4, 1, 1, 0,  0, 0,  0, 0,  0, 0, 1, 0, 1);
    vecs[7]  = mk(4,  0,  0,  0,  4, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(0,  0,  0,  0,  0, 1, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0);
    vecs[9]  = mk(4,  0,  0,  0,  4, 1, 1, 0,  0, 0,  0, 1,  0, 0, 0, 0, 1);
    vecs[10] = mk(0,  0,  5,  0,  0, 0, 0, 5,  1, 0,  0, 1,  1, 0, 0, 0, 1);
    vecs[11] = mk(4,  0,  0,  0,  4, 1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0);
    vecs[12] = mk(0,  0,  3,  4,  0, 0, 0, 4,  1, 3,  1, 0,  2, 1, 0, 0, 0);

    // Reset state, with inputs that would otherwise forward and stall.
    clr_in();
    aclr = 1'b0;
    dx_rs1 = 5'd5; xm_rd = 5'd5; xm_regwr = 1; set_lu();
    #1;
    chk("rst.fwd_a", 32'(fwd_a), 0);
    chk_stall("rst", 0, 0, 0);
    chk("rst.md_busy", 32'(md_busy), 0);
    chk("rst.md_done", 32'(md_done), 0);
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    repeat (2) @(negedge clock);
    aclr = 1'b1; clr_in();
    #1 chk("rel.stall_cnt", 32'(stall_cnt), 0);

    // Single load-use cycle: stall+bubble, counter 0 -> 1.
    @(negedge clock); set_lu();
    #1 chk_stall("lu1", 1, 0, 1);
    chk("lu1.stall_cnt", 32'(stall_cnt), 0);
    @(negedge clock); clr_in();
    #1 chk_stall("lu1.after", 0, 0, 0);
    chk("lu1.stall_cnt_after", 32'(stall_cnt), 1);

    // Combinational vector table (IDLE, no multdiv).
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      fd_rs1 = vecs[i].fd1; fd_rs2 = vecs[i].fd2; dx_rs1 = vecs[i].rs1; dx_rs2 = vecs[i].rs2;
      dx_rd = vecs[i].rd; dx_regwr = vecs[i].regwr; dx_load = vecs[i].load;
      xm_rd = vecs[i].xrd; xm_regwr = vecs[i].xwr; mw_rd = vecs[i].mrd; mw_regwr = vecs[i].mwr;
      flush = vecs[i].fl; dx_md_start = 0;
      #1;
      chk($sformatf("vec%0d.fwd_a", i), 32'(fwd_a), 32'(vecs[i].efa));
      chk($sformatf("vec%0d.fwd_b", i), 32'(fwd_b), 32'(vecs[i].efb));
      chk_stall($sformatf("vec%0d", i), vecs[i].esf, vecs[i].esd, vecs[i].ebb);
    end

    // Full multdiv op: 7 busy cycles then done on cycle 8. Load-use during
    // busy must not bubble; a second start during busy is ignored.
    @(negedge clock); clr_in(); dx_md_start = 1;
    #1 chk("md.idle_busy", 32'(md_busy), 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      clr_in();
      dx_md_start = (c == 4);
      if (c == 2) set_lu();
      #1;
      chk($sformatf("md.c%0d.busy", c), 32'(md_busy), 1);
      chk($sformatf("md.c%0d.done", c), 32'(md_done), 0);
      chk_stall($sformatf("md.c%0d", c), 1, 1, 0);
    end
    @(negedge clock); clr_in();
    #1 chk("md.c8.done", 32'(md_done), 1);
    chk("md.c8.busy", 32'(md_busy), 0);
    chk_stall("md.c8", 0, 0, 0);
    @(negedge clock);
    #1 chk("md.c9.done", 32'(md_done), 0);
    chk("md.c9.busy", 32'(md_busy), 0);

    // Flush on busy cycle 3 aborts without a done pulse.
    @(negedge clock); clr_in(); dx_md_start = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      dx_md_start = 0; flush = (c == 3);
      #1;
      if (c < 3) chk($sformatf("fl.c%0d.stall_fd", c), 32'(stall_fd), 1);
      else       chk_stall("fl.c3", 0, 0, 1);
    end
    for (int c = 4; c <= 10; c++) begin
      @(negedge clock); flush = 0;
      #1 chk($sformatf("fl.c%0d.busy", c), 32'(md_busy), 0);
      chk($sformatf("fl.c%0d.done", c), 32'(md_done), 0);
    end

    // Reset on busy cycle 4, then a fresh op takes exactly 8 cycles, and a
    // start in the DONE cycle goes straight back to BUSY.
    @(negedge clock); clr_in(); dx_md_start = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock); dx_md_start = 0;
      #1 chk($sformatf("ar.c%0d.busy", c), 32'(md_busy), 1);
    end
    @(negedge clock);
    dx_rs1 = 5'd5; xm_rd = 5'd5; xm_regwr = 1; set_lu();
    #1 chk("ar.c4.pre_busy", 32'(md_busy), 1);
    aclr = 1'b0;
    #1 chk("ar.c4.busy", 32'(md_busy), 0);
    chk("ar.c4.done", 32'(md_done), 0);
    chk("ar.c4.fwd_a", 32'(fwd_a), 0);
    chk("ar.c4.stall_cnt", 32'(stall_cnt), 0);
    chk_stall("ar.c4", 0, 0, 0);
    @(negedge clock); aclr = 1'b1; clr_in();
    #1 chk("ar.rel.busy", 32'(md_busy), 0);
    chk("ar.rel.done", 32'(md_done), 0);
    dx_md_start = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock); dx_md_start = (c == 8);
      #1;
      chk($sformatf("ar.n%0d.busy", c), 32'(md_busy), (c < 8) ? 1 : 0);
      chk($sformatf("ar.n%0d.done", c), 32'(md_done), (c < 8) ? 0 : 1);
    end
    @(negedge clock); dx_md_start = 0;
    #1 chk("ar.b2b.busy", 32'(md_busy), 1);

    // Stall counter saturation with SCW=4.
    @(negedge clock); clr_in(); aclr = 1'b0;
    #1 chk("sat.rst", 32'(stall_cnt), 0);
    @(negedge clock); aclr = 1'b1; set_lu();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      #1;
      if (i == 14) chk("sat.14", 32'(stall_cnt), 14);
    end
    chk("sat.20", 32'(stall_cnt), 15);
    chk("sat.stall_fd", 32'(stall_fd), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
